// File: rtl/relu_layer_sequencer.sv
// relu_layer_sequencer
// Streams an N_ELEM-element signed fixed-point vector from an input memory through one
// shared ReLU datapath into an output memory, counting strictly positive elements.
// Block-level control follows the ap_ctrl_hs handshake.
//
// Ports:
//   ap_clk, ap_rst             clock (rising edge) and synchronous active-high reset
//   ap_start                   request to process one vector (sampled only in IDLE)
//   ap_done, ap_ready          one-cycle pulse when the vector is complete
//   ap_idle                    high while waiting for ap_start
//   x_address0, x_ce0, x_q0    input memory read port (data one cycle after x_ce0)
//   y_address0, y_ce0, y_we0   output memory write port
//   y_d0                       ReLU result, DATA_W-1 bits
//   n_pos                      count of elements > 0, stable from ap_done to next start
module relu_layer_sequencer #(
    parameter int DATA_W = 32,
    parameter int N_ELEM = 16,
    parameter int ADDR_W = 4
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    output logic [ADDR_W-1:0] x_address0,
    output logic              x_ce0,
    input  logic [DATA_W-1:0] x_q0,
    output logic [ADDR_W-1:0] y_address0,
    output logic              y_ce0,
    output logic              y_we0,
    output logic [DATA_W-2:0] y_d0,
    output logic [ADDR_W:0]   n_pos
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [ADDR_W:0]   NElem    = (ADDR_W + 1)'(N_ELEM);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(N_ELEM - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W:0]   rd_idx_q, rd_idx_d;   // next element to read
    logic              x_ce_q, x_ce_d;
    logic [ADDR_W-1:0] x_addr_q, x_addr_d;
    logic              wr_vld_q, wr_vld_d;   // x_q0 carries valid data this cycle
    logic [ADDR_W-1:0] y_addr_q, y_addr_d;
    logic [DATA_W-2:0] y_hold_q, y_hold_d;   // last written result, held between writes
    logic [ADDR_W:0]   n_pos_q, n_pos_d;

    logic              x_pos;
    logic [DATA_W-2:0] relu_val;

    always_comb begin
        // Strictly positive: sign clear and at least one magnitude bit set.
        x_pos    = ~x_q0[DATA_W-1] & (|x_q0[DATA_W-2:0]);
        relu_val = x_pos ? x_q0[DATA_W-2:0] : '0;

        state_d  = state_q;
        rd_idx_d = rd_idx_q;
        x_ce_d   = 1'b0;
        x_addr_d = x_addr_q;
        wr_vld_d = 1'b0;
        y_addr_d = y_addr_q;
        y_hold_d = y_hold_q;
        n_pos_d  = n_pos_q;

        case (state_q)
            StIdle: begin
                if (ap_start) begin
                    state_d  = StRun;
                    x_ce_d   = 1'b1;
                    x_addr_d = '0;
                    rd_idx_d = (ADDR_W + 1)'(1);
                    n_pos_d  = '0;
                end
            end
            StRun: begin
                if (rd_idx_q < NElem) begin
                    x_ce_d   = 1'b1;
                    x_addr_d = rd_idx_q[ADDR_W-1:0];
                    rd_idx_d = rd_idx_q + (ADDR_W + 1)'(1);
                end
                // Write side trails the read side by one cycle.
                wr_vld_d = x_ce_q;
                if (x_ce_q) begin
                    y_addr_d = x_addr_q;
                end
                if (wr_vld_q) begin
                    y_hold_d = relu_val;
                    if (x_pos) begin
                        n_pos_d = n_pos_q + (ADDR_W + 1)'(1);
                    end
                    if (y_addr_q == LastAddr) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q  <= StIdle;
            rd_idx_q <= '0;
            x_ce_q   <= 1'b0;
            x_addr_q <= '0;
            wr_vld_q <= 1'b0;
            y_addr_q <= '0;
            y_hold_q <= '0;
            n_pos_q  <= '0;
        end else begin
            state_q  <= state_d;
            rd_idx_q <= rd_idx_d;
            x_ce_q   <= x_ce_d;
            x_addr_q <= x_addr_d;
            wr_vld_q <= wr_vld_d;
            y_addr_q <= y_addr_d;
            y_hold_q <= y_hold_d;
            n_pos_q  <= n_pos_d;
        end
    end

    always_comb begin
        ap_idle    = (state_q == StIdle);
        ap_done    = (state_q == StDone);
        ap_ready   = (state_q == StDone);
        x_ce0      = x_ce_q;
        x_address0 = x_addr_q;
        y_ce0      = wr_vld_q;
        y_we0      = wr_vld_q;
        y_address0 = y_addr_q;
        // The result is combinational from x_q0 on write cycles, otherwise the held value.
        y_d0       = wr_vld_q ? relu_val : y_hold_q;
        n_pos      = n_pos_q;
    end

endmodule

// File: tb/tb_relu_layer_sequencer.sv
// Testbench for relu_layer_sequencer: expected writes and done events are queued by the
// stimulus and consumed by a negedge monitor; a second instance covers N_ELEM=1.
module tb_relu_layer_sequencer;

    logic        clk = 1'b0;
    logic        ap_rst;
    logic        ap_start;
    logic        ap_done, ap_idle, ap_ready;
    logic [3:0]  x_address0, y_address0;
    logic        x_ce0, y_ce0, y_we0;
    logic [31:0] x_q0;
    logic [30:0] y_d0;
    logic [4:0]  n_pos;

    logic        ap_start1;
    logic        ap_done1, ap_idle1, ap_ready1;
    logic [0:0]  x1_address0, y1_address0;
    logic        x1_ce0, y1_ce0, y1_we0;
    logic [31:0] x1_q0;
    logic [30:0] y1_d0;
    logic [1:0]  n1_pos;

    always #5 clk = ~clk;

    relu_layer_sequencer #(.DATA_W(32), .N_ELEM(16), .ADDR_W(4)) dut (
        .ap_clk(clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_done(ap_done),
        .ap_idle(ap_idle), .ap_ready(ap_ready), .x_address0(x_address0), .x_ce0(x_ce0),
        .x_q0(x_q0), .y_address0(y_address0), .y_ce0(y_ce0), .y_we0(y_we0), .y_d0(y_d0),
        .n_pos(n_pos)
    );

    relu_layer_sequencer #(.DATA_W(32), .N_ELEM(1), .ADDR_W(1)) dut1 (
        .ap_clk(clk), .ap_rst(ap_rst), .ap_start(ap_start1), .ap_done(ap_done1),
        .ap_idle(ap_idle1), .ap_ready(ap_ready1), .x_address0(x1_address0), .x_ce0(x1_ce0),
        .x_q0(x1_q0), .y_address0(y1_address0), .y_ce0(y1_ce0), .y_we0(y1_we0),
        .y_d0(y1_d0), .n_pos(n1_pos)
    );

    // Input memories with one-cycle read latency.
    logic [31:0] xmem [16];
    logic [31:0] x1mem;
    always @(posedge clk) if (x_ce0) x_q0 <= xmem[x_address0];
    always @(posedge clk) if (x1_ce0) x1_q0 <= x1mem;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, exp, cyc);
    endtask

    typedef struct { logic [3:0] addr; logic [30:0] data; } wr_t;
    typedef struct { int when; logic [4:0] npos; } done_t;
    wr_t   exp_wr[$];
    done_t exp_done[$];

    // Scoreboard monitor.
    int    wr_cnt = 0;
    wr_t   mw;
    done_t md;
    always @(negedge clk) begin
        if (y_we0) begin
            chk("y_ce0 with y_we0", y_ce0, 1);
            if (exp_wr.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected write: addr=%0h data=%0h, expected no write",
                         y_address0, y_d0);
            end else begin
                mw = exp_wr.pop_front();
                chk("write address", y_address0, mw.addr);
                chk("write data", y_d0, mw.data);
            end
            wr_cnt++;
        end
        if (ap_done) begin
            chk("ap_ready with ap_done", ap_ready, 1);
            if (exp_done.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected ap_done at cyc %0d, expected none", cyc);
            end else begin
                md = exp_done.pop_front();
                chk("ap_done cycle", cyc, md.when);
                chk("n_pos at done", n_pos, md.npos);
                chk("writes per vector", wr_cnt, 16);
            end
            wr_cnt = 0;
        end
        if (ap_rst) wr_cnt = 0;
    end

    task automatic at_cyc(input int t);
        @(negedge clk);
        while (cyc < t) @(negedge clk);
    endtask

    // Returns c0 such that cycle k of the run is observed where cyc == c0 + k.
    task automatic launch(output int c0);
        @(negedge clk);
        ap_start = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc - 1;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!ap_idle && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle within bound", ap_idle, 1);
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 16; i++) xmem[i] = 32'(i - 8);
    endtask

    task automatic push_ramp();
        wr_t w;
        for (int i = 0; i < 16; i++) begin
            w.addr = 4'(i);
            w.data = (i > 8) ? 31'(i - 8) : 31'd0;
            exp_wr.push_back(w);
        end
    endtask

    logic [31:0] bnd_x [16] = '{32'h7FFFFFFF, 32'h80000000, 32'h00000000, 32'h00000001,
                                32'hFFFFFFFF, 32'h80000001, 32'h00000100, 32'h40000000,
                                32'hC0000000, 32'h7FFFFFFE, 32'hFFFFFF00, 32'h00012345,
                                32'hFFFFFFFE, 32'h00000000, 32'hEDCBA988, 32'hF0000000};
    logic [30:0] bnd_y [16] = '{31'h7FFFFFFF, 31'h0, 31'h0, 31'h1,
                                31'h0, 31'h0, 31'h100, 31'h40000000,
                                31'h0, 31'h7FFFFFFE, 31'h0, 31'h12345,
                                31'h0, 31'h0, 31'h0, 31'h0};

    task automatic push_bnd(input int count);
        wr_t w;
        for (int i = 0; i < count; i++) begin
            w.addr = 4'(i);
            w.data = bnd_y[i];
            exp_wr.push_back(w);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        ap_rst    = 1'b1;
        ap_start  = 1'b0;
        ap_start1 = 1'b0;
        x1mem     = 32'h00000100;
        repeat (3) @(negedge clk);

        // Reset values.
        chk("reset ap_idle", ap_idle, 1);
        chk("reset ap_done", ap_done, 0);
        chk("reset ap_ready", ap_ready, 0);
        chk("reset x_ce0", x_ce0, 0);
        chk("reset y_we0", y_we0, 0);
        chk("reset y_ce0", y_ce0, 0);
        chk("reset x_address0", x_address0, 0);
        chk("reset y_address0", y_address0, 0);
        chk("reset y_d0", y_d0, 0);
        chk("reset n_pos", n_pos, 0);

        // Reset wins over a simultaneous start.
        ap_start = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst+start idle", ap_idle, 1);
        chk("rst+start x_ce0", x_ce0, 0);
        ap_start = 1'b0;
        ap_rst   = 1'b0;
        @(negedge clk);
        chk("after rst still idle", ap_idle, 1);

        // Ramp vector x[i] = i-8.
        load_ramp();
        push_ramp();
        launch(c0);
        exp_done.push_back('{c0 + 18, 5'd7});
        at_cyc(c0 + 1);
        ap_start = 1'b0;
        chk("c1 ap_idle", ap_idle, 0);
        chk("c1 x_ce0", x_ce0, 1);
        chk("c1 x_address0", x_address0, 0);
        chk("c1 y_we0", y_we0, 0);
        at_cyc(c0 + 2);
        chk("c2 x_address0", x_address0, 1);
        chk("c2 y_we0", y_we0, 1);
        at_cyc(c0 + 18);
        chk("done y_we0 low", y_we0, 0);
        chk("done x_ce0 low", x_ce0, 0);
        chk("hold y_address0", y_address0, 15);
        chk("hold y_d0", y_d0, 7);
        chk("hold x_address0", x_address0, 15);
        at_cyc(c0 + 19);
        chk("c19 idle", ap_idle, 1);
        chk("n_pos stable in idle", n_pos, 7);

        // Boundary vector.
        for (int i = 0; i < 16; i++) xmem[i] = bnd_x[i];
        push_bnd(16);
        launch(c0);
        exp_done.push_back('{c0 + 18, 5'd6});
        at_cyc(c0 + 1);
        ap_start = 1'b0;
        wait_idle();

        // ap_start held high for three vectors.
        load_ramp();
        push_ramp();
        push_ramp();
        push_ramp();
        launch(c0);
        exp_done.push_back('{c0 + 18, 5'd7});
        exp_done.push_back('{c0 + 37, 5'd7});
        exp_done.push_back('{c0 + 56, 5'd7});
        for (int k = 1; k <= 58; k++) begin
            at_cyc(c0 + k);
            chk($sformatf("held ap_idle c%0d", k), ap_idle, (k == 19 || k == 38 || k >= 57));
            if (k == 20 || k == 39) chk($sformatf("n_pos cleared c%0d", k), n_pos, 0);
            if (k == 56) ap_start = 1'b0;
        end

        // Reset in cycle 8 of a run.
        for (int i = 0; i < 16; i++) xmem[i] = bnd_x[i];
        push_bnd(7);
        launch(c0);
        at_cyc(c0 + 1);
        ap_start = 1'b0;
        at_cyc(c0 + 8);
        ap_rst = 1'b1;
        at_cyc(c0 + 9);
        chk("mid-rst x_ce0", x_ce0, 0);
        chk("mid-rst y_we0", y_we0, 0);
        chk("mid-rst ap_idle", ap_idle, 1);
        chk("mid-rst ap_done", ap_done, 0);
        chk("mid-rst n_pos", n_pos, 0);
        chk("mid-rst y_d0", y_d0, 0);
        ap_rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("no writes after rst", exp_wr.size(), 0);
        push_bnd(16);
        launch(c0);
        exp_done.push_back('{c0 + 18, 5'd6});
        at_cyc(c0 + 1);
        ap_start = 1'b0;
        wait_idle();

        // Start pulses during RUN and DONE are ignored.
        load_ramp();
        push_ramp();
        launch(c0);
        exp_done.push_back('{c0 + 18, 5'd7});
        at_cyc(c0 + 1);
        ap_start = 1'b0;
        at_cyc(c0 + 5);
        ap_start = 1'b1;
        at_cyc(c0 + 6);
        ap_start = 1'b0;
        at_cyc(c0 + 18);
        ap_start = 1'b1;
        at_cyc(c0 + 19);
        ap_start = 1'b0;
        chk("pulse c19 idle", ap_idle, 1);
        at_cyc(c0 + 20);
        chk("pulse c20 idle", ap_idle, 1);
        chk("pulse c20 x_ce0", x_ce0, 0);

        // N_ELEM=1 instance.
        @(negedge clk);
        ap_start1 = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc - 1;
        at_cyc(c0 + 1);
        ap_start1 = 1'b0;
        chk("n1 c1 x_ce0", x1_ce0, 1);
        chk("n1 c1 x_address0", x1_address0, 0);
        chk("n1 c1 y_we0", y1_we0, 0);
        at_cyc(c0 + 2);
        chk("n1 c2 y_we0", y1_we0, 1);
        chk("n1 c2 y_ce0", y1_ce0, 1);
        chk("n1 c2 y_address0", y1_address0, 0);
        chk("n1 c2 y_d0", y1_d0, 31'h100);
        chk("n1 c2 x_ce0", x1_ce0, 0);
        at_cyc(c0 + 3);
        chk("n1 c3 ap_done", ap_done1, 1);
        chk("n1 c3 ap_ready", ap_ready1, 1);
        chk("n1 c3 n_pos", n1_pos, 1);
        chk("n1 c3 y_we0", y1_we0, 0);
        at_cyc(c0 + 4);
        chk("n1 c4 ap_done", ap_done1, 0);
        chk("n1 c4 ap_idle", ap_idle1, 1);

        repeat (3) @(negedge clk);
        chk("write queue drained", exp_wr.size(), 0);
        chk("done queue drained", exp_done.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
